sr04_ranger: RTL
================

# sr04_ranger

Parametrised HC-SR04 ultrasonic ranging engine that replaces the fixed 100 MHz controller and the separate 1 µs tick generator. It issues the trigger pulse, times the echo with an internal microsecond prescaler, and converts echo width to centimetres with a divider-free 58 µs sub-counter. It adds echo-wait and echo-high timeouts, a mandatory hold-off between shots, and an auto-repeat mode. It sits between the debounced start button or auto-enable switch and the distance display/UART path.

## Interface
- CLK_HZ, 100_000_000: input clock frequency. DIV = CLK_HZ/1_000_000 must be an integer ≥ 2.
- TRIG_US, 10: trigger high width in µs.
- TIMEOUT_US, 30_000: limit in µs for both the echo-rise wait and the echo-high width.
- HOLDOFF_US, 60_000: idle gap in µs after every shot, whether it succeeds or times out.
- DIST_W, 9: width of the distance output.
- clk  in  1  system clock.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- start  in  1  one-cycle request pulse. Honoured only in IDLE.
- auto_en  in  1  level. While high, a new shot starts automatically from IDLE.
- echo  in  1  asynchronous sensor echo pin. Synchronised internally through 2 flops.
- trigger  out  1  sensor trigger, registered.
- dist_cm  out  DIST_W  last valid distance in cm. Held until the next valid result.
- dist_valid  out  1  one-cycle pulse when dist_cm updates.
- timeout  out  1  one-cycle pulse when a shot is aborted.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- Prescaler: counts 0..DIV-1. A µs tick fires when it reaches DIV-1. The prescaler, µs counter, 58-counter and cm counter all clear on every state transition, so each state's duration is an exact multiple of DIV cycles.
- Echo is sampled through echo_s1 → echo_s2. The FSM uses only echo_s2.
- States: IDLE, TRIG, WAIT_ECHO, MEASURE, HOLDOFF.
- IDLE: trigger = 0.
  - (start | auto_en) → TRIG.
  - start arriving in any other state is dropped; requests are not queued.
- TRIG: trigger = 1.
  - After TRIG_US ticks → WAIT_ECHO, with trigger = 0 on the same edge.
- WAIT_ECHO:
  - echo_s2 = 1 → MEASURE.
  - TIMEOUT_US ticks elapse first → pulse timeout, go to HOLDOFF.
- MEASURE: on each tick, us_cnt increments and sub58 increments. When sub58 = 57 it wraps to 0 and cm_cnt increments, saturating at 2^DIST_W−1.
  - echo_s2 = 0 → dist_cm ← cm_cnt (= floor(us_cnt/58)), pulse dist_valid, go to HOLDOFF.
  - us_cnt reaches TIMEOUT_US with echo still high → pulse timeout, leave dist_cm unchanged, go to HOLDOFF.
- HOLDOFF: after HOLDOFF_US ticks → IDLE. Echo is ignored in this state.
- A timeout and a valid result never occur in the same shot. If echo falls on the same cycle the timeout count is reached, the valid result wins.
- Counter widths derive from $clog2 of the parameters. There is no overflow before the timeout limit.

## Timing
- Reset values: trigger 0, dist_cm 0, dist_valid 0, timeout 0, busy 0, state IDLE, all counters 0, sync flops 0.
- rst asserted in any state (including mid-TRIG or mid-MEASURE): all of the above values apply on the next edge. No partial result and no timeout pulse are emitted.
- start sampled high at edge n → trigger = 1 and busy = 1 after edge n+1.
- trigger stays high for exactly TRIG_US·DIV cycles.
- Echo pin low first sampled at edge k → dist_valid and the new dist_cm are visible after edge k+2. The echo-rise path has the same 2-cycle sync latency.
- A timeout pulse occurs exactly TIMEOUT_US·DIV cycles after entering WAIT_ECHO or MEASURE.
- Auto mode: the shot period is TRIG_US + (echo wait + echo width) + HOLDOFF_US µs, plus sync and transition cycles. busy drops for exactly one cycle in IDLE between shots.
- dist_valid and timeout are never high together and never high for more than 1 cycle.

## Test plan
Bench parameters: CLK_HZ = 10_000_000 (DIV = 10), TIMEOUT_US = 2000, HOLDOFF_US = 100.
- Single shot, 580 µs echo: start pulse → trigger high for 100 cycles; echo rises 50 µs later and is held 580 µs → dist_cm = 10, one dist_valid pulse, busy low after 1000 cycles of HOLDOFF.
- Rounding and range: echo of 1159 µs → 19; 1160 µs → 20; 57 µs → 0 (dist_valid still pulses).
- No echo: start, echo held at 0 → timeout pulse 20000 cycles after trigger falls; dist_cm keeps its prior value; then HOLDOFF, then IDLE.
- Echo stuck high for 3000 µs → timeout pulse at 2000 µs into MEASURE; no dist_valid; returns to IDLE after HOLDOFF.
- Auto mode with echo of 290 µs every shot → continuous shots, dist_cm = 5 each time, one-cycle busy gap in IDLE. A start pulse issued mid-shot neither adds a shot nor disturbs timing.
- Reset mid-MEASURE (synchronous rst for 1 cycle) → all outputs at reset values on the next edge; the following start produces a clean, correct measurement.

Source files
------------

// File: rtl/sr04_ranger.sv
// HC-SR04 ultrasonic ranging engine: trigger generation, echo timing with an internal
// microsecond prescaler, divider-free centimetre conversion, timeouts, hold-off and auto-repeat.
`timescale 1ns/1ps
module sr04_ranger #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TRIG_US    = 10,
  parameter int TIMEOUT_US = 30_000,
  parameter int HOLDOFF_US = 60_000,
  parameter int DIST_W     = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              auto_en,
  input  logic              echo,
  output logic              trigger,
  output logic [DIST_W-1:0] dist_cm,
  output logic              dist_valid,
  output logic              timeout,
  output logic              busy
);

  localparam int DIV     = CLK_HZ / 1_000_000;
  localparam int PRE_W   = $clog2(DIV);
  localparam int US_MAX0 = (TIMEOUT_US > HOLDOFF_US) ? TIMEOUT_US : HOLDOFF_US;
  localparam int US_MAX  = (US_MAX0 > TRIG_US) ? US_MAX0 : TRIG_US;
  localparam int US_W    = $clog2(US_MAX + 1);

  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(DIV - 1);
  localparam logic [US_W-1:0]  TRIG_LAST = US_W'(TRIG_US - 1);
  localparam logic [US_W-1:0]  TOUT_LAST = US_W'(TIMEOUT_US - 1);
  localparam logic [US_W-1:0]  HOLD_LAST = US_W'(HOLDOFF_US - 1);
  localparam logic [5:0]       SUB_LAST  = 6'd57;

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_ECHO, MEASURE, HOLDOFF} state_t;

  // All timing counters live together so a state change can clear them in one assignment.
  typedef struct packed {
    logic [PRE_W-1:0]  pre;
    logic [US_W-1:0]   us;
    logic [5:0]        sub58;
    logic [DIST_W-1:0] cm;
  } cnt_t;

  state_t            state;
  cnt_t              cnt;
  logic              echo_s1;
  logic              echo_s2;
  logic              start_q;
  logic              tick;
  logic              sub_wrap;
  logic [DIST_W-1:0] cm_step;
  logic [DIST_W-1:0] cm_final;

  function automatic logic [DIST_W-1:0] sat_inc(input logic [DIST_W-1:0] v);
    return (&v) ? v : v + DIST_W'(1);
  endfunction

  // The tick landing on the echo-fall edge still counts toward the result.
  always_comb begin
    tick     = (cnt.pre == PRE_LAST);
    sub_wrap = (cnt.sub58 == SUB_LAST);
    cm_step  = sat_inc(cnt.cm);
    cm_final = (tick && sub_wrap) ? cm_step : cnt.cm;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      echo_s1    <= 1'b0;
      echo_s2    <= 1'b0;
      start_q    <= 1'b0;
      trigger    <= 1'b0;
      dist_cm    <= '0;
      dist_valid <= 1'b0;
      timeout    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      echo_s1    <= echo;
      echo_s2    <= echo_s1;
      start_q    <= start && (state == IDLE);
      dist_valid <= 1'b0;
      timeout    <= 1'b0;
      cnt.pre    <= tick ? '0 : cnt.pre + PRE_W'(1);
      if (tick) cnt.us <= cnt.us + US_W'(1);

      case (state)
        IDLE: begin
          cnt <= '0;
          if (start_q || auto_en) begin
            state   <= TRIG;
            trigger <= 1'b1;
            busy    <= 1'b1;
          end
        end

        TRIG: begin
          if (tick && cnt.us == TRIG_LAST) begin
            state   <= WAIT_ECHO;
            trigger <= 1'b0;
            cnt     <= '0;
          end
        end

        WAIT_ECHO: begin
          if (echo_s2) begin
            state <= MEASURE;
            cnt   <= '0;
          end else if (tick && cnt.us == TOUT_LAST) begin
            state   <= HOLDOFF;
            timeout <= 1'b1;
            cnt     <= '0;
          end
        end

        // Echo falling takes priority over a coincident timeout.
        MEASURE: begin
          if (tick) begin
            cnt.sub58 <= sub_wrap ? '0 : cnt.sub58 + 6'd1;
            if (sub_wrap) cnt.cm <= cm_step;
          end
          if (!echo_s2) begin
            state      <= HOLDOFF;
            dist_cm    <= cm_final;
            dist_valid <= 1'b1;
            cnt        <= '0;
          end else if (tick && cnt.us == TOUT_LAST) begin
            state   <= HOLDOFF;
            timeout <= 1'b1;
            cnt     <= '0;
          end
        end

        HOLDOFF: begin
          if (tick && cnt.us == HOLD_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end
        end

        default: begin
          state   <= IDLE;
          trigger <= 1'b0;
          busy    <= 1'b0;
          cnt     <= '0;
        end
      endcase
    end
  end

endmodule
